// File: rtl/tone_generator.sv
// tone_generator: divisor-driven square wave with PCM samples for the codec.
// Define TONE_RAMP_EN to add the FADING state and a 16-tick amplitude envelope.
module tone_generator #(
  parameter int DIV_W = 32,
  parameter int AMP_W = 16,
  parameter logic [AMP_W-1:0] AMPLITUDE = 16'h2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_in,
  input  logic             enable,
  input  logic             sample_tick,
  output logic             square,
  output logic [AMP_W-1:0] audio_out,
  output logic             audio_valid,
  output logic             playing
);

`ifdef TONE_RAMP_EN
  typedef enum logic [1:0] {
    SILENT,
    PLAYING,
    FADING
  } state_t;
  localparam state_t STOP_TO = FADING;
`else
  typedef enum logic [0:0] {
    SILENT,
    PLAYING
  } state_t;
  localparam state_t STOP_TO = SILENT;
`endif

  state_t state, state_nxt;

  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_reg, div_nxt;
  logic [DIV_W-1:0] half;
  logic             start_ok;
  logic             wrap;
  logic [AMP_W-1:0] env_nxt;
  logic [AMP_W-1:0] sample;

  assign start_ok = enable && (div_in > DIV_W'(1));
  assign wrap     = (cnt == div_reg - DIV_W'(1));
  assign half     = div_reg >> 1;
  assign playing  = (state != SILENT);

`ifdef TONE_RAMP_EN
  localparam logic [AMP_W-1:0] STEP = AMPLITUDE >> 4;

  logic [AMP_W-1:0] env;
  logic [AMP_W-1:0] env_up;
  logic [AMP_W-1:0] env_dn;

  assign env_up = (env >= AMPLITUDE - STEP) ? AMPLITUDE
                                            : env + STEP;
  assign env_dn = (env <= STEP) ? '0 : env - STEP;

  always_comb begin
    env_nxt = env;
    if (sample_tick) begin
      unique case (state)
        PLAYING: env_nxt = env_up;
        FADING:  env_nxt = env_dn;
        default: env_nxt = env;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env <= '0;
    end else begin
      env <= env_nxt;
    end
  end
`else
  assign env_nxt = AMPLITUDE;
`endif

  // Divisor is only ever loaded from SILENT or at a wrap,
  // so a running period is never cut short.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div_reg;
    unique case (state)
      SILENT: begin
        cnt_nxt = '0;
        if (start_ok) begin
          div_nxt   = div_in;
          state_nxt = PLAYING;
        end
      end
      PLAYING: begin
        cnt_nxt = cnt + DIV_W'(1);
        if (wrap) begin
          cnt_nxt = '0;
          if (start_ok) begin
            div_nxt = div_in;
          end else begin
            state_nxt = STOP_TO;
          end
        end
      end
`ifdef TONE_RAMP_EN
      FADING: begin
        cnt_nxt = cnt + DIV_W'(1);
        if (wrap) begin
          cnt_nxt = '0;
        end
        if (wrap && start_ok) begin
          div_nxt   = div_in;
          state_nxt = PLAYING;
        end else if (env_nxt == '0) begin
          cnt_nxt   = '0;
          state_nxt = SILENT;
        end
      end
`endif
      default: begin
        cnt_nxt   = '0;
        state_nxt = SILENT;
      end
    endcase
  end

  // Sign comes from the pre-edge square, so a tick on a wrap
  // edge still reports the half-period that just ended.
  always_comb begin
    sample = '0;
    if (state != SILENT) begin
      sample = square ? env_nxt : '0 - env_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SILENT;
      cnt         <= '0;
      div_reg     <= '0;
      square      <= 1'b0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      div_reg     <= div_nxt;
      square      <= (state != SILENT) && (cnt < half);
      audio_valid <= sample_tick;
      if (sample_tick) begin
        audio_out <= sample;
      end
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: directed checks of tone_generator.
// Ramp checks are compiled in when TONE_RAMP_EN is defined.
module tb_tone_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] div_in;
  logic        enable;
  logic        sample_tick;
  logic        square;
  logic [15:0] audio_out;
  logic        audio_valid;
  logic        playing;

  int n_tests = 0;
  int n_fail  = 0;

  tone_generator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_in      (div_in),
    .enable      (enable),
    .sample_tick (sample_tick),
    .square      (square),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .playing     (playing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] d);
    rst_n       = 1'b0;
    enable      = 1'b0;
    sample_tick = 1'b0;
    step();
    rst_n  = 1'b1;
    div_in = d;
    enable = 1'b1;
    step();
  endtask

  function automatic logic [15:0] mag(input logic [15:0] v);
    return v[15] ? 16'(16'd0 - v) : v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable      = 1'b1;
    div_in      = 32'd10;
    sample_tick = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_sq", 32'(square), 32'd0);
      chk("rst_pcm", 32'(audio_out), 32'd0);
      chk("rst_vld", 32'(audio_valid), 32'd0);
      chk("rst_play", 32'(playing), 32'd0);
    end

    sample_tick = 1'b0;
    rst_n = 1'b1;
    step();
    chk("entry_play", 32'(playing), 32'd1);
    chk("entry_sq", 32'(square), 32'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("even_sq", 32'(square), 32'((k % 10) < 5));
    end

`ifndef TONE_RAMP_EN
    sample_tick = 1'b1;
    step();
    chk("pcm_lo", 32'(audio_out), 32'h0000_e000);
    chk("pcm_lo_vld", 32'(audio_valid), 32'd1);
    step();
    chk("pcm_hi", 32'(audio_out), 32'h0000_2000);
    chk("pcm_hi_vld", 32'(audio_valid), 32'd1);
    sample_tick = 1'b0;
    step();
    chk("pcm_vld_drop", 32'(audio_valid), 32'd0);
    chk("pcm_hold", 32'(audio_out), 32'h0000_2000);
    enable = 1'b0;
    for (int i = 0; i < 20 && playing; i++) begin
      step();
    end
    chk("stop_play", 32'(playing), 32'd0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("pcm_silent", 32'(audio_out), 32'd0);
    chk("pcm_silent_vld", 32'(audio_valid), 32'd1);
    step();
    chk("pcm_silent_drop", 32'(audio_valid), 32'd0);
`endif

    start(32'd7);
    for (int k = 0; k < 14; k++) begin
      step();
      chk("odd_sq", 32'(square), 32'((k % 7) < 3));
    end

    for (int d = 0; d < 2; d++) begin
      rst_n = 1'b0;
      step();
      rst_n  = 1'b1;
      div_in = 32'(d);
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step();
      end
      chk("sil_play", 32'(playing), 32'd0);
      chk("sil_sq", 32'(square), 32'd0);
    end

    start(32'd10);
    for (int k = 0; k < 22; k++) begin
      step();
      chk("chg_sq", 32'(square),
          k < 10 ? 32'(k < 5) : 32'(((k - 10) % 6) < 3));
      if (k == 2) div_in = 32'd6;
    end

`ifndef TONE_RAMP_EN
    start(32'd10);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("drop_sq", 32'(square), 32'(k < 5));
      chk("drop_play", 32'(playing), 32'(k < 9));
      if (k == 1) enable = 1'b0;
    end
`else
    start(32'd10);
    sample_tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ramp_up", 32'(mag(audio_out)),
          i < 16 ? 32'((i + 1) * 32'h200) : 32'h2000);
    end
    sample_tick = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
    end
    chk("fade_play", 32'(playing), 32'd1);
    sample_tick = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("fade_mag", 32'(mag(audio_out)),
          32'h2000 - 32'((i + 1) * 32'h200));
      chk("fade_end", 32'(playing), 32'(i < 15));
    end
    sample_tick = 1'b0;

    start(32'd10);
    sample_tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
    end
    sample_tick = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
    end
    sample_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    sample_tick = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rstfade_env", 32'(dut.env), 32'd0);
    chk("rstfade_play", 32'(playing), 32'd0);
    chk("rstfade_pcm", 32'(audio_out), 32'd0);
    rst_n  = 1'b1;
    div_in = 32'd10;
    enable = 1'b1;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("rstfade_reramp", 32'(mag(audio_out)), 32'h200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
